// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the default RAM base address.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between LSB-aligned CPU data and the word-organised RAM:
// store byte enables/replicated data, and load extraction with extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    input  logic        zext,
    input  logic [31:0] raw,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    // NOTE: every output of a combinational block is given a default before
    // the case statement; a path that leaves one unassigned infers a latch.
    always_comb begin
        be         = 4'b0000;
        wdata_lane = wdata;
        shifted    = raw >> {off, 3'b000};
        rdata      = 32'h0;
        case (size)
            SZ_B: begin
                be         = 4'b0001 << off;
                wdata_lane = {4{wdata[7:0]}};
                rdata      = zext ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                be         = off[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata      = zext ? {16'h0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                be    = 4'b1111;
                rdata = raw;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: one request at a time over valid/ready, byte/half/word
// access to an internal RAM, response returned LATENCY cycles after acceptance.
module mem_responder
    import mem_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];

    logic [31:0]       off;
    logic [ADDR_W-1:0] idx;
    logic              out_of_range, misaligned, bad_size, err, accept, we;
    logic [3:0]        be;
    logic [31:0]       wdata_lane, load_data;

    // Subtracting the base in 32-bit unsigned arithmetic makes addresses below
    // BASE_ADDR wrap to huge offsets, so one compare catches both ends.
    assign off          = req_addr - BASE_ADDR;
    assign out_of_range = (off >> (ADDR_W + 2)) != 32'h0;
    assign misaligned   = ((req_size == SZ_H) && off[0]) ||
                          ((req_size == SZ_W) && (off[1:0] != 2'b00));
    assign bad_size     = (req_size == 2'd3);
    assign err          = out_of_range | misaligned | bad_size;
    assign idx          = off[ADDR_W+1:2];
    assign accept       = req_valid & req_ready;
    assign we           = accept & req_wen & ~err;

    mem_lane_align u_align (
        .size       (req_size),
        .off        (off[1:0]),
        .wdata      (req_wdata),
        .be         (be),
        .wdata_lane (wdata_lane),
        .zext       (req_unsigned),
        .raw        (mem[idx]),
        .rdata      (load_data)
    );

    // NOTE: the RAM has no reset branch; clearing every word would forbid a
    // block-RAM mapping, and software never relies on its initial contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt       <= CNT_INIT;
                rsp_err   <= err;
                rsp_rdata <= (err || req_wen) ? 32'h0 : load_data;
            end else if (state == WAIT && cnt != 4'h0) begin
                cnt <= cnt - 4'h1;
            end
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = (LATENCY > 1) ? WAIT : RESP;
            end
            WAIT: begin
                if (cnt == 4'h0) state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever a response handshakes.
module tb_mem_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mem_responder #(.ADDR_W(12), .LATENCY(3), .BASE_ADDR(32'h8000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wen      (req_wen),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata=%h err=%b, expected no response",
                         rsp_rdata, rsp_err);
            end else begin
                e = exp_q.pop_front();
                check({e.name, ".rdata"}, rsp_rdata, e.rdata);
                check({e.name, ".err"}, 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready && exp_q.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: got req_ready=%b, expected 1 within 50 cycles", req_ready);
    endtask

    task automatic wait_rsp(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL %s.timeout: got no response, expected one within 50 cycles", name);
        exp_q.delete();
    endtask

    // Drives one request; returns 1 ns after its acceptance edge.
    task automatic send(input string name, input logic [31:0] addr, input logic wen,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input bit push);
        exp_t e;
        wait_idle();
        @(posedge clk); #1;
        req_addr     = addr;
        req_wen      = wen;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        if (push) begin
            e.name  = name;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic ld(input string name, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] exp_rdata, input logic exp_err);
        send(name, addr, 1'b0, size, uns, 32'h0, exp_rdata, exp_err, 1'b1);
        wait_rsp(name);
    endtask

    task automatic st(input string name, input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] wdata, input logic exp_err);
        send(name, addr, 1'b1, size, 1'b0, wdata, 32'h0, exp_err, 1'b1);
        wait_rsp(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_addr     = 32'h0;
        req_wen      = 1'b0;
        req_size     = SZ_W;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;
        rsp_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'h0);
        check("rst.rsp_err", 32'(rsp_err), 32'd0);

        // Word store then sub-word reads back.
        st("st_w_deadbeef", 32'h8000_0010, SZ_W, 32'hDEAD_BEEF, 1'b0);
        ld("ld_b_s_13",     32'h8000_0013, SZ_B, 1'b0, 32'hFFFF_FFDE, 1'b0);
        ld("ld_b_u_13",     32'h8000_0013, SZ_B, 1'b1, 32'h0000_00DE, 1'b0);
        ld("ld_h_s_10",     32'h8000_0010, SZ_H, 1'b0, 32'hFFFF_BEEF, 1'b0);
        ld("ld_w_10",       32'h8000_0010, SZ_W, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // Partial stores merge into the existing word.
        st("st_b_11",       32'h8000_0011, SZ_B, 32'h0000_00AB, 1'b0);
        ld("ld_w_after_b",  32'h8000_0010, SZ_W, 1'b0, 32'hDEAD_ABEF, 1'b0);
        st("st_h_12",       32'h8000_0012, SZ_H, 32'h0000_1234, 1'b0);
        ld("ld_w_after_h",  32'h8000_0010, SZ_W, 1'b0, 32'h1234_ABEF, 1'b0);
        ld("ld_h_u_12",     32'h8000_0012, SZ_H, 1'b1, 32'h0000_1234, 1'b0);
        ld("ld_b_s_11",     32'h8000_0011, SZ_B, 1'b0, 32'hFFFF_FFAB, 1'b0);

        // Latency 3 and response backpressure.
        rsp_ready = 1'b0;
        send("ld_bp", 32'h8000_0010, 1'b0, SZ_W, 1'b0, 32'h0, 32'h1234_ABEF, 1'b0, 1'b1);
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                k = i;
                break;
            end
        end
        check("latency_cycles", 32'(k), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.rsp_rdata", rsp_rdata, 32'h1234_ABEF);
            check("bp.req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_rsp("ld_bp");
        @(negedge clk);
        check("bp.req_ready_after", 32'(req_ready), 32'd1);

        // Error responses must not disturb RAM.
        st("st_w_base",     32'h8000_0000, SZ_W, 32'h1122_3344, 1'b0);
        ld("err_ld_w_mis",  32'h8000_0002, SZ_W, 1'b0, 32'h0, 1'b1);
        st("err_st_h_mis",  32'h8000_0011, SZ_H, 32'h0000_5678, 1'b1);
        st("err_st_w_mis",  32'h8000_0002, SZ_W, 32'hFFFF_FFFF, 1'b1);
        ld("err_ld_below",  32'h7FFF_FFFC, SZ_W, 1'b0, 32'h0, 1'b1);
        ld("err_ld_above",  32'h8000_4000, SZ_W, 1'b0, 32'h0, 1'b1);
        ld("err_ld_size3",  32'h8000_0000, 2'd3, 1'b0, 32'h0, 1'b1);
        st("err_st_size3",  32'h8000_0000, 2'd3, 32'hFFFF_FFFF, 1'b1);
        ld("ld_w_base_chk", 32'h8000_0000, SZ_W, 1'b0, 32'h1122_3344, 1'b0);
        ld("ld_w_10_chk",   32'h8000_0010, SZ_W, 1'b0, 32'h1234_ABEF, 1'b0);

        // Last word of the RAM is in range.
        st("st_w_top",      32'h8000_3FFC, SZ_W, 32'hCAFE_F00D, 1'b0);
        ld("ld_w_top",      32'h8000_3FFC, SZ_W, 1'b0, 32'hCAFE_F00D, 1'b0);

        // Reset during WAIT: response dropped, store kept.
        send("st_rst", 32'h8000_0020, 1'b1, SZ_W, 1'b0, 32'h55AA_55AA, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst.req_ready", 32'(req_ready), 32'd1);
        check("midrst.rsp_valid_rel", 32'(rsp_valid), 32'd0);
        check("midrst.rsp_rdata", rsp_rdata, 32'h0);
        check("midrst.rsp_err", 32'(rsp_err), 32'd0);
        repeat (5) begin
            @(negedge clk);
            check("midrst.no_rsp", 32'(rsp_valid), 32'd0);
        end
        ld("ld_w_20", 32'h8000_0020, SZ_W, 1'b0, 32'h55AA_55AA, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
